// File: rtl/clk_div_cfg_initiator.sv
// clk_div_cfg_initiator: control-domain initiator of the 4-phase divider config handshake.
// Single pending slot (latest wins), ack synchroniser, per-phase timeout.
module clk_div_cfg_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] DIV_INIT = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_req_i,
    input  logic [DATA_WIDTH-1:0] cfg_data_i,
    output logic                  busy_o,
    output logic                  pending_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] cur_div_o,
    output logic [DATA_WIDTH-1:0] clk_div_data_o,
    output logic                  clk_div_valid_o,
    input  logic                  clk_div_ack_i
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, REL} state_e;
    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [CW-1:0]           cnt_q;
    logic                    pend_q, valid_q, done_q, timeout_q, err_q;
    logic [DATA_WIDTH-1:0]   pend_data_q, data_q, cur_q;
    logic                    ack_s, launch, expire;
    always_comb begin
        ack_s  = sync_q[SYNC_STAGES-1];
        // a still-high ack from an aborted handshake must not be taken as a new completion
        launch = (cfg_req_i | pend_q) & ~ack_s;
        expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= DIV_INIT;
            cur_q       <= DIV_INIT;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_div_ack_i};
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (cfg_req_i && (state_q != IDLE || ack_s)) begin
                pend_q      <= 1'b1;
                pend_data_q <= cfg_data_i;
            end
            case (state_q)
                IDLE: if (launch) begin
                    data_q  <= cfg_req_i ? cfg_data_i : pend_data_q;
                    pend_q  <= 1'b0;
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= REQ;
                end
                REQ: if (ack_s) begin
                    cur_q   <= data_q;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= REL;
                end else if (expire) begin
                    valid_q   <= 1'b0;
                    cnt_q     <= '0;
                    timeout_q <= 1'b1;
                    err_q     <= 1'b1;
                    state_q   <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                REL: if (!ack_s) begin
                    cnt_q   <= '0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end else if (expire) begin
                    cnt_q     <= '0;
                    timeout_q <= 1'b1;
                    err_q     <= 1'b1;
                    state_q   <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o          = state_q != IDLE;
    assign pending_o       = pend_q;
    assign done_o          = done_q;
    assign timeout_o       = timeout_q;
    assign err_o           = err_q;
    assign cur_div_o       = cur_q;
    assign clk_div_data_o  = data_q;
    assign clk_div_valid_o = valid_q;
endmodule

// File: tb/tb_clk_div_cfg_initiator.sv
// tb_clk_div_cfg_initiator: directed scenarios plus randomized traffic against a
// transaction-level model of the divider config handshake.
module tb_clk_div_cfg_initiator;
    localparam int DW = 8, S = 2, T = 16;
    localparam logic [DW-1:0] DI = 8'h5A;
    logic clk = 0, rst = 1, cfg_req = 0, ack = 0;
    logic [DW-1:0] cfg_data = '0;
    logic busy, pend, done, tmo, err, valid;
    logic [DW-1:0] cur, dat;
    clk_div_cfg_initiator #(.DATA_WIDTH(DW), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T), .DIV_INIT(DI)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_req_i(cfg_req), .cfg_data_i(cfg_data),
        .busy_o(busy), .pending_o(pend), .done_o(done), .timeout_o(tmo), .err_o(err),
        .cur_div_o(cur), .clk_div_data_o(dat), .clk_div_valid_o(valid), .clk_div_ack_i(ack)
    );
    always #5 clk = ~clk;
    int vecs = 0, errs = 0;
    int mode = 0, stall_pct = 0;
    // model: phase 0=idle 1=waiting for ack high 2=waiting for ack low
    int cyc = 0, start = 0, m_phase = 0;
    bit [S-1:0] hist = '0;
    logic m_valid = 0, m_pend = 0, m_done = 0, m_to = 0, m_err = 0;
    logic [DW-1:0] m_data = DI, m_cur = DI, m_pdata = '0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    task automatic abort_phase();
        m_phase = 0; m_valid = 0; m_to = 1; m_err = 1;
    endtask
    task automatic model_step();
        bit acks;
        cyc++;
        if (rst) begin
            m_phase = 0; hist = '0; m_valid = 0; m_pend = 0; m_done = 0; m_to = 0; m_err = 0;
            m_data = DI; m_cur = DI;
            return;
        end
        acks = hist[S-1];
        hist = {hist[S-2:0], ack};
        m_done = 0; m_to = 0;
        if (cfg_req && (m_phase != 0 || acks)) begin m_pend = 1; m_pdata = cfg_data; end
        if (m_phase == 0) begin
            if ((cfg_req || m_pend) && !acks) begin
                m_data = cfg_req ? cfg_data : m_pdata;
                m_pend = 0; m_valid = 1; m_err = 0; m_phase = 1; start = cyc + 1;
            end
        end else if (m_phase == 1) begin
            if (acks) begin m_cur = m_data; m_valid = 0; m_phase = 2; start = cyc + 1; end
            else if (cyc - start == T - 1) abort_phase();
        end else begin
            if (!acks) begin m_phase = 0; m_done = 1; end
            else if (cyc - start == T - 1) abort_phase();
        end
    endtask
    task automatic compare();
        chk("busy", busy, m_phase != 0);
        chk("pending", pend, m_pend);
        chk("done", done, m_done);
        chk("timeout", tmo, m_to);
        chk("err", err, m_err);
        chk("cur_div", cur, m_cur);
        chk("data", dat, m_data);
        chk("valid", valid, m_valid);
    endtask
    task automatic respond();
        if (mode == 1) ack = 0;
        else if (mode == 2) ack = 1;
        else if ($urandom_range(99) >= stall_pct) ack = valid;
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        respond();
        cfg_req = 0;
    endtask
    task automatic req(input logic [DW-1:0] d);
        cfg_req = 1; cfg_data = d; tick();
    endtask
    task automatic wait_done();
        for (int i = 0; i < 100 && !done; i++) tick();
        chk("done_seen", done, 1);
    endtask
    int n;
    initial begin
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rst_cur", cur, 8'h5A); chk("rst_data", dat, 8'h5A); chk("rst_valid", valid, 0);
        // basic
        req(8'h05);
        chk("basic_valid", valid, 1); chk("basic_data", dat, 8'h05);
        wait_done();
        chk("basic_cur", cur, 8'h05); chk("basic_busy", busy, 0);
        // pending overwrite
        req(8'h03); req(8'h07); req(8'h09);
        chk("pend_set", pend, 1);
        n = 0;
        for (int i = 0; i < 60; i++) begin tick(); if (done) n++; end
        chk("pend_dones", n, 2); chk("pend_cur", cur, 8'h09);
        // request in the done cycle
        req(8'h20);
        wait_done();
        req(8'h11);
        chk("same_valid", valid, 1); chk("same_data", dat, 8'h11); chk("same_pend", pend, 0);
        wait_done();
        // timeout
        mode = 1; ack = 0;
        req(8'h21);
        n = 0;
        for (int i = 0; i < 40; i++) begin if (!valid) break; n++; tick(); end
        chk("to_len", n, 16); chk("to_pulse", tmo, 1); chk("to_err", err, 1); chk("to_cur", cur, 8'h11);
        tick();
        chk("to_pulse_end", tmo, 0);
        // stale ack
        mode = 2; ack = 1;
        repeat (3) tick();
        req(8'h33);
        chk("stale_pend", pend, 1); chk("stale_valid", valid, 0);
        repeat (2) tick();
        chk("stale_err", err, 1);
        mode = 0; stall_pct = 0; ack = 0;
        repeat (2) tick();
        chk("stale_hold", valid, 0);
        tick();
        chk("stale_launch", valid, 1); chk("stale_data", dat, 8'h33); chk("stale_errclr", err, 0);
        wait_done();
        // reset mid-handshake
        req(8'h44); tick();
        rst = 1; tick(); rst = 0;
        chk("mid_valid", valid, 0); chk("mid_cur", cur, 8'h5A); chk("mid_done", done, 0); chk("mid_to", tmo, 0);
        repeat (4) tick();
        req(8'h55);
        wait_done();
        chk("mid_recover", cur, 8'h55);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 2) begin
                n = $urandom_range(9);
                mode = n < 7 ? 0 : n < 9 ? 1 : 2;
                stall_pct = $urandom_range(60);
            end
            rst = $urandom_range(999) < 3;
            cfg_req = $urandom_range(99) < 15;
            cfg_data = 8'($urandom);
            tick();
        end
        rst = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
